// File: rtl/nvram_save_ctrl.sv
// nvram_save_ctrl: tracks battery-RAM writes and streams the NVRAM image to a save sink.
module nvram_save_ctrl #(
    parameter int AUTOSAVE_CE = 1789773
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic [21:0] prg_aout,
    input  logic        prg_write,
    input  logic        prg_allow,
    input  logic [3:0]  nvram_size,
    input  logic        save_req,
    output logic [21:0] mem_addr,
    output logic        mem_rd,
    input  logic        mem_ack,
    input  logic [7:0]  mem_din,
    output logic [7:0]  sd_data,
    output logic        sd_valid,
    input  logic        sd_ready,
    output logic        busy,
    output logic        dirty,
    output logic        done
);
    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, PUSH, DONE} state_t;
    localparam logic [20:0] AS_MAX = 21'(AUTOSAVE_CE);
    state_t state, nxt;
    logic [15:0] size, size_q;
    logic [14:0] idx;
    logic [20:0] timer;
    logic [7:0]  data_q;
    logic        dirty_q, trk, fire, start, clean, last, ack_in, hs;
    assign size   = nvram_size == 4'd7 ? 16'd8192 : nvram_size == 4'd9 ? 16'd32768 : 16'd0;
    assign trk    = ce & prg_write & prg_allow & (prg_aout[21:15] == 7'b1111000) & ({1'b0, prg_aout[14:0]} < size);
    assign fire   = timer == AS_MAX;
    assign start  = (state == IDLE) & (save_req | fire) & (size != 16'd0) & dirty_q;
    assign clean  = (state == IDLE) & save_req & (size != 16'd0) & ~dirty_q;
    assign last   = {1'b0, idx} == size_q - 16'd1;
    assign ack_in = (state == RD_REQ || state == RD_WAIT) & mem_ack;
    assign hs     = (state == PUSH) & sd_ready;
    always_ff @(posedge clk)
        state <= reset ? IDLE : nxt;
    always_comb begin
        nxt = state == IDLE ? (start ? RD_REQ : clean ? DONE : IDLE)
            : (state == RD_REQ || state == RD_WAIT) ? (mem_ack ? PUSH : RD_WAIT)
            : state == PUSH ? (sd_ready ? (last ? DONE : RD_REQ) : PUSH)
            : IDLE;
    end
    always_comb begin
        mem_rd   = state == RD_REQ || state == RD_WAIT;
        sd_valid = state == PUSH;
        busy     = state != IDLE;
        done     = state == DONE;
    end
    // a tracked write outranks the start-clear so a write racing the save start is not lost
    always_ff @(posedge clk) begin
        if (reset) begin
            idx     <= '0;
            size_q  <= '0;
            data_q  <= '0;
            dirty_q <= 1'b0;
            timer   <= '0;
        end else begin
            idx     <= start ? '0 : (hs && !last) ? idx + 15'd1 : idx;
            size_q  <= start ? size : size_q;
            data_q  <= ack_in ? mem_din : data_q;
            dirty_q <= trk ? 1'b1 : start ? 1'b0 : dirty_q;
            timer   <= (trk || !dirty_q || start) ? '0
                     : (ce && state == IDLE && timer != AS_MAX) ? timer + 21'd1 : timer;
        end
    end
    assign mem_addr = {7'b1111000, idx};
    assign sd_data  = data_q;
    assign dirty    = dirty_q;
endmodule

// File: tb/tb_nvram_save_ctrl.sv
// tb_nvram_save_ctrl: directed checks of write tracking, save streaming, autosave and reset abort.
module tb_nvram_save_ctrl;
    logic        clk = 0, reset = 1, ce = 1, prg_write = 0, prg_allow = 1, save_req = 0;
    logic        mem_ack = 0, sd_ready = 0;
    logic [21:0] prg_aout = '0;
    logic [3:0]  nvram_size = '0;
    logic [7:0]  mem_din = '0;
    logic [21:0] mem_addr;
    logic [7:0]  sd_data;
    logic        mem_rd, sd_valid, busy, dirty, done;
    int checks = 0, errors = 0;
    int bytes, addr_err, data_err, stab_err, excl_err, done_cnt, fin;
    logic [21:0] last_addr;

    always #5 clk = ~clk;

    nvram_save_ctrl #(.AUTOSAVE_CE(100)) dut (
        .clk(clk), .reset(reset), .ce(ce), .prg_aout(prg_aout), .prg_write(prg_write),
        .prg_allow(prg_allow), .nvram_size(nvram_size), .save_req(save_req),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_ack(mem_ack), .mem_din(mem_din),
        .sd_data(sd_data), .sd_valid(sd_valid), .sd_ready(sd_ready),
        .busy(busy), .dirty(dirty), .done(done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] dfun(input logic [21:0] a);
        return a[7:0] ^ a[15:8];
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [21:0] a);
        prg_aout = a;
        prg_write = 1;
        cyc();
        prg_write = 0;
    endtask

    // memory responder with fixed latency, stream sink and scoreboard for one save
    task automatic run_save(input int lat, input bit rnd, input int wr_at, input int rst_at,
                            input int chg_at, input bit req);
        int wc = 0;
        bit in_req = 0, held = 0, wrote = 0;
        logic [7:0] hd = '0;
        bytes = 0; addr_err = 0; data_err = 0; stab_err = 0; excl_err = 0;
        done_cnt = 0; fin = 0; last_addr = '0;
        if (req) begin
            save_req = 1;
            cyc();
            save_req = 0;
        end
        for (int c = 0; c < 90000; c++) begin
            prg_write = 0;
            if (mem_rd && sd_valid) excl_err++;
            if (done) done_cnt++;
            if (!busy) begin
                fin = 1;
                break;
            end
            if (mem_rd && bytes == rst_at) begin
                reset = 1;
                mem_ack = 0;
                fin = 1;
                break;
            end
            if (mem_rd) begin
                if (!in_req) begin
                    in_req = 1;
                    wc = 0;
                    if (mem_addr !== 22'h3C0000 + 22'(bytes)) addr_err++;
                end
                mem_ack = (wc == lat);
                mem_din = dfun(mem_addr);
                wc++;
                last_addr = mem_addr;
                if (bytes == wr_at && !wrote) begin
                    prg_aout = 22'h3C0100;
                    prg_write = 1;
                    wrote = 1;
                end
            end else begin
                in_req = 0;
                mem_ack = 0;
            end
            if (sd_valid) begin
                if (held && sd_data !== hd) stab_err++;
                if (sd_data !== dfun(22'h3C0000 + 22'(bytes))) data_err++;
                sd_ready = rnd ? ($urandom_range(0, 15) != 0) : 1'b1;
                held = !sd_ready;
                hd = sd_data;
                if (sd_ready) bytes++;
                if (bytes == chg_at) nvram_size = 4'd9;
            end else begin
                if (held) stab_err++;
                held = 0;
                sd_ready = rnd ? ($urandom_range(0, 1) != 0) : 1'b1;
            end
            cyc();
        end
        mem_ack = 0;
        sd_ready = 0;
        prg_write = 0;
    endtask

    initial begin
        int b, r, d, kb;
        cyc();
        cyc();
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_sd_valid", sd_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dirty", dirty, 0);
        chk("rst_mem_addr", mem_addr, 22'h3C0000);
        chk("rst_sd_data", sd_data, 0);
        reset = 0;
        cyc();

        wr(22'h3C0000);
        chk("nosize_dirty", dirty, 0);
        b = 0; r = 0;
        save_req = 1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            b += int'(busy);
            r += int'(mem_rd);
        end
        save_req = 0;
        chk("nosize_busy", b, 0);
        chk("nosize_mem_rd", r, 0);
        chk("nosize_dirty_after", dirty, 0);

        nvram_size = 4'd7;
        ce = 0;
        wr(22'h3C0010);
        ce = 1;
        chk("ce_gate", dirty, 0);
        prg_allow = 0;
        wr(22'h3C0010);
        prg_allow = 1;
        chk("allow_gate", dirty, 0);
        wr(22'h3C2000);
        chk("range_gate", dirty, 0);
        wr(22'h380010);
        chk("bank_gate", dirty, 0);
        wr(22'h3C0010);
        chk("dirty_set8k", dirty, 1);

        run_save(0, 0, -1, -1, 100, 1);
        chk("a_finished", fin, 1);
        chk("a_bytes", bytes, 8192);
        chk("a_addr_order", addr_err, 0);
        chk("a_data", data_err, 0);
        chk("a_excl", excl_err, 0);
        chk("a_done_cnt", done_cnt, 1);
        chk("a_last_addr", last_addr, 22'h3C1FFF);
        chk("a_dirty_after", dirty, 0);

        wr(22'h3C7FFF);
        chk("dirty_set32k", dirty, 1);
        run_save(0, 1, 50, -1, -1, 1);
        chk("b_finished", fin, 1);
        chk("b_bytes", bytes, 32768);
        chk("b_last_addr", last_addr, 22'h3C7FFF);
        chk("b_addr_order", addr_err, 0);
        chk("b_data", data_err, 0);
        chk("b_stable", stab_err, 0);
        chk("b_excl", excl_err, 0);
        chk("b_done_cnt", done_cnt, 1);
        chk("b_midsave_dirty", dirty, 1);
        reset = 1;
        cyc();
        reset = 0;
        chk("b_reset_dirty", dirty, 0);

        nvram_size = 4'd7;
        kb = 0;
        prg_aout = 22'h3C0010;
        prg_write = 1;
        for (int i = 1; i <= 400; i++) begin
            cyc();
            prg_write = (i == 60);
            if (busy) begin
                kb = i;
                break;
            end
        end
        prg_write = 0;
        chk("autosave_tick", kb, 162);
        chk("autosave_dirty_clr", dirty, 0);
        chk("autosave_addr", mem_addr, 22'h3C0000);

        run_save(2, 0, -1, 20, -1, 0);
        chk("c_reached_idx20", fin, 1);
        chk("c_bytes", bytes, 20);
        chk("c_addr_order", addr_err, 0);
        cyc();
        reset = 0;
        chk("abort_busy", busy, 0);
        chk("abort_mem_rd", mem_rd, 0);
        chk("abort_sd_valid", sd_valid, 0);
        chk("abort_dirty", dirty, 0);
        chk("abort_done", done, 0);
        chk("abort_no_done_before", done_cnt, 0);

        d = 0; r = 0;
        save_req = 1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            save_req = 0;
            d += int'(done);
            r += int'(mem_rd);
        end
        chk("clean_done_cnt", d, 1);
        chk("clean_mem_rd", r, 0);
        chk("clean_dirty", dirty, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
